// File: rtl/data_ram_if.sv
// Load/store port between the MEM stage (master) and the data memory (slave).
// Carries request address, lane select, store data, plus load data and ready back.
interface data_ram_if;
  logic        ram_en_i;
  logic        mem_write_en_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_select_i;
  logic [31:0] store_data_i;
  logic [31:0] ram_data_o;
  logic        ram_ready_o;

  modport master (
    output ram_en_i, mem_write_en_i, mem_addr_i, mem_select_i, store_data_i,
    input  ram_data_o, ram_ready_o
  );

  modport slave (
    input  ram_en_i, mem_write_en_i, mem_addr_i, mem_select_i, store_data_i,
    output ram_data_o, ram_ready_o
  );
endinterface

// File: rtl/data_ram.sv
// Word-organised data memory with byte-masked stores; optional post-reset clear (DATA_RAM_CLEAR_EN).
// Latency: loads combinational (same cycle), stores committed at the clock edge.
// Backpressure: none per request; ram_ready_o low (reset/clear) means requests are ignored.
module data_ram #(
  parameter int ADDR_W = 10
) (
  input logic       clk,
  input logic       rst,
  data_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              ready;
  logic              wr_en;
  logic              rd_en;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign idx = bus.mem_addr_i[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0]};

`ifdef DATA_RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && (&clr_idx)) begin
      state_nxt = READY;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= READY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
  end
`endif

  always_comb begin
    ready = ~rst & (state == READY);
    wr_en = ready & bus.ram_en_i & bus.mem_write_en_i;
    rd_en = ready & bus.ram_en_i & ~bus.mem_write_en_i;
  end

  always_ff @(posedge clk) begin
`ifdef DATA_RAM_CLEAR_EN
    if (!rst && state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else
`endif
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.mem_select_i[k]) begin
          mem[idx][8*k +: 8] <= bus.store_data_i[8*k +: 8];
        end
      end
    end
  end

  assign bus.ram_ready_o = ready;
  assign bus.ram_data_o  = rd_en ? mem[idx] : 32'h0;
endmodule

// File: tb/tb_data_ram.sv
// Scoreboarded random/directed bench for data_ram at ADDR_W=4, either clear-engine build.
module tb_data_ram;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_ram_if bus ();

  data_ram #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        r;
    string       nm;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [DEPTH];
  logic        rdy_exp = 1'b0;
  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc = 0;

  // Cycles since the last cycle with rst high.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every enabled request cycle consumes one scoreboard entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.ram_en_i === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL scoreboard underflow: request seen with no expectation queued");
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.nm, " data"}, bus.ram_data_o, mon_e.d);
        check({mon_e.nm, " ready"}, {31'b0, bus.ram_ready_o}, {31'b0, mon_e.r});
      end
    end else begin
      check("idle data", bus.ram_data_o, 32'h0);
    end
  end

  task automatic drive(input logic en, input logic we, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input string nm,
                       input logic use_lit, input logic [31:0] lit);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    bus.ram_en_i       = en;
    bus.mem_write_en_i = we;
    bus.mem_addr_i     = a;
    bus.mem_select_i   = s;
    bus.store_data_i   = d;
    if (en) begin
      w    = int'((a / 4) % DEPTH);
      e.nm = nm;
      e.r  = rdy_exp;
      e.d  = 32'h0;
      if (rdy_exp && !we) e.d = use_lit ? lit : mdl[w];
      if (rdy_exp && we) begin
        for (int k = 0; k < 4; k++)
          if (s[k]) mdl[w][8*k +: 8] = d[8*k +: 8];
      end
      sbq.push_back(e);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input string nm);
    drive(1'b1, 1'b1, a, s, d, nm, 1'b0, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input string nm);
    drive(1'b1, 1'b0, a, 4'($urandom), $urandom, nm, 1'b0, 32'h0);
  endtask

  task automatic ldx(input logic [31:0] a, input logic [31:0] lit, input string nm);
    drive(1'b1, 1'b0, a, 4'($urandom), $urandom, nm, 1'b1, lit);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "idle", 1'b0, 32'h0);
  endtask

  task automatic rst_on();
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.ram_en_i = 1'b0;
    rdy_exp      = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
`endif
  endtask

  task automatic rst_off();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.ram_en_i = 1'b0;
`ifndef DATA_RAM_CLEAR_EN
    rdy_exp = 1'b1;
`endif
  endtask

  task automatic wait_ready(input int exp_cyc, input string nm);
    int n    = 0;
    bit seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (bus.ram_ready_o === 1'b1) seen = 1;
      else n++;
    end
    if (!seen) begin
      n_chk++;
      n_bad++;
      $display("FAIL %s: ready never rose within 100 cycles", nm);
    end else begin
      check(nm, 32'(cyc), 32'(exp_cyc));
    end
    rdy_exp = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ram_en_i       = 1'b0;
    bus.mem_write_en_i = 1'b0;
    bus.mem_addr_i     = 32'h0;
    bus.mem_select_i   = 4'h0;
    bus.store_data_i   = 32'h0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    repeat (2) @(posedge clk);
    ld(32'h4, "load in rst");
    st(32'h4, 4'hF, 32'hFFFF_FFFF, "store in rst");
    idle();
    rst_off();
`ifdef DATA_RAM_CLEAR_EN
    st(32'h4, 4'hF, 32'hFFFF_FFFF, "store in clear");
    ld(32'h4, "load in clear");
    idle();
    wait_ready(DEPTH, "ready latency");
`else
    wait_ready(0, "ready latency");
    for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 4'hF, 32'h0, "init");
`endif

    for (int i = 0; i < DEPTH; i++)
      ldx(32'(i * 4 + i % 4) | ($urandom << 6), 32'h0, "zero word");
    ldx(32'h4, 32'h0, "addr4 after clear");

    st(32'h8, 4'hF, 32'hDEAD_BEEF, "full store");
    st(32'h9, 4'b0100, 32'h5555_5555, "lane store");
    ldx(32'h8, 32'hDE55_BEEF, "lane merge");
    st(32'h10, 4'hF, 32'h1122_3344, "word store");
    st(32'h12, 4'b0011, 32'hA5A5_A5A5, "half store");
    ldx(32'h10, 32'h1122_A5A5, "halfword merge");
    st(32'h40, 4'hF, 32'hCAFE_F00D, "wrap store");
    ldx(32'h0, 32'hCAFE_F00D, "wrap load");
    st(32'h20, 4'b0000, 32'hFFFF_FFFF, "sel0 store");
    ldx(32'h20, 32'h0, "sel0 noop");

    for (int i = 0; i < 300; i++)
      drive(($urandom % 4) != 0, $urandom_range(0, 1) == 1, $urandom,
            4'($urandom), $urandom, "random", 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) ld(32'(i * 4), "sweep");

    rst_on();
    ld(32'h8, "load in rst2");
    rst_off();
`ifdef DATA_RAM_CLEAR_EN
    repeat (4) idle();
    rst_on();
    rst_off();
    wait_ready(DEPTH, "ready after mid-clear rst");
`else
    wait_ready(0, "ready after rst");
`endif
    for (int i = 0; i < DEPTH; i++) ld(32'(i * 4), "post-rst sweep");

    idle();
    idle();
    check("scoreboard empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
